// File: rtl/llki_reg_arbiter.sv
// llki_reg_arbiter: round-robin share of one register target
// capture -> issue -> wait-for-ack -> respond, with ack watchdog
module llki_reg_arbiter #(
    parameter int NumReq        = 2,
    parameter int RegAw         = 8,
    parameter int RegDw         = 32,
    parameter int TimeoutCycles = 255,
    localparam int RegBw        = RegDw / 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NumReq-1:0]         req_re_i,
    input  logic [NumReq-1:0]         req_we_i,
    input  logic [NumReq*RegAw-1:0]   req_addr_i,
    input  logic [NumReq*RegDw-1:0]   req_wdata_i,
    input  logic [NumReq*RegBw-1:0]   req_be_i,
    output logic [NumReq-1:0]         req_gnt_o,
    output logic [NumReq-1:0]         req_ack_o,
    output logic [RegDw-1:0]          req_rdata_o,
    output logic                      req_error_o,
    output logic                      re_o,
    output logic                      we_o,
    output logic [RegAw-1:0]          addr_o,
    output logic [RegDw-1:0]          wdata_o,
    output logic [RegBw-1:0]          be_o,
    input  logic [RegDw-1:0]          rdata_i,
    input  logic                      ack_i,
    input  logic                      error_i,
    output logic                      busy_o
);

    localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CntW-1:0] CntMax  = CntW'(TimeoutCycles);
    localparam logic [CntW-1:0] CntLast =
        (TimeoutCycles > 0) ? CntW'(TimeoutCycles - 1) : '0;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NumReq - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
    typedef enum logic [1:0] {OP_RD, OP_WR, OP_ILL} op_e;

    state_e            state_q, state_d;
    op_e               op_q;
    logic [IdxW-1:0]   ptr_q;
    logic [IdxW-1:0]   idx_q;
    logic [IdxW-1:0]   win_idx;
    logic              win_valid;
    logic              win_both;
    logic [NumReq-1:0] pending;
    logic [RegAw-1:0]  addr_q;
    logic [RegDw-1:0]  wdata_q;
    logic [RegBw-1:0]  be_q;
    logic [RegDw-1:0]  rdata_q;
    logic              err_q;
    logic [CntW-1:0]   cnt_q;
    logic              cap_cmd;
    logic              cap_rsp;
    logic              set_err;
    logic              cnt_clr;
    logic              cnt_inc;
    logic              adv_ptr;
    logic              timeout_hit;

    assign pending     = req_re_i | req_we_i;
    assign win_both    = req_re_i[win_idx] & req_we_i[win_idx];
    assign timeout_hit = (TimeoutCycles != 0) && (cnt_q == CntLast);

    // First pending requester scanning upward from the priority pointer
    always_comb begin
        int j;
        j         = 0;
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NumReq; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NumReq) j = j - NumReq;
            if (!win_valid && pending[j]) begin
                win_valid = 1'b1;
                win_idx   = IdxW'(j);
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and datapath strobes
    always_comb begin
        state_d = state_q;
        cap_cmd = 1'b0;
        cap_rsp = 1'b0;
        set_err = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        adv_ptr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    cap_cmd = 1'b1;
                    state_d = win_both ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                cnt_clr = 1'b1;
                if (ack_i) begin
                    cap_rsp = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (ack_i) begin
                    cap_rsp = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_inc = 1'b1;
                    if (timeout_hit) begin
                        set_err = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                adv_ptr = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Holding registers, watchdog counter and priority pointer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q    <= OP_RD;
            idx_q   <= '0;
            ptr_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (cap_cmd) begin
                idx_q   <= win_idx;
                addr_q  <= req_addr_i[int'(win_idx)*RegAw +: RegAw];
                wdata_q <= req_wdata_i[int'(win_idx)*RegDw +: RegDw];
                be_q    <= req_be_i[int'(win_idx)*RegBw +: RegBw];
                rdata_q <= '0;
                err_q   <= win_both;
                if (win_both)               op_q <= OP_ILL;
                else if (req_re_i[win_idx]) op_q <= OP_RD;
                else                        op_q <= OP_WR;
            end
            if (cap_rsp) begin
                rdata_q <= (op_q == OP_RD) ? rdata_i : '0;
                err_q   <= error_i;
            end
            if (set_err) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (cnt_inc && cnt_q != CntMax) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (adv_ptr) begin
                ptr_q <= (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
            end
        end
    end

    assign req_gnt_o = (state_q == IDLE && win_valid && !rst_i) ?
                       (NumReq'(1) << win_idx) : '0;
    assign req_ack_o   = (state_q == RESP) ? (NumReq'(1) << idx_q) : '0;
    assign req_rdata_o = (state_q == RESP) ? rdata_q : '0;
    assign req_error_o = (state_q == RESP) ? err_q : 1'b0;
    assign re_o        = (state_q == ISSUE) && (op_q == OP_RD);
    assign we_o        = (state_q == ISSUE) && (op_q == OP_WR);
    assign addr_o      = addr_q;
    assign wdata_o     = wdata_q;
    assign be_o        = be_q;
    assign busy_o      = (state_q != IDLE);

endmodule
